request_fifo: RTL

//   Parametrised, multi-entry successor to the single-register request memory: a synchronous FIFO of floor requests.

---
 rtl/request_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/request_fifo.sv
// Synchronous request FIFO with registered input stage and status flags.
// Define REQ_FIFO_DEDUP_EN to drop writes that match a held entry.
module request_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         q,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     dup_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en_sync;
  logic [WIDTH-1:0] data_in_sync;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;
  logic             ovf_nxt;
  logic             is_dup;
  logic [CW-1:0]    count_nxt;

`ifdef REQ_FIFO_DEDUP_EN
  logic [PW-1:0] off;

  // Entries from rd_ptr onward, up to count, are live (incl. one being read).
  always_comb begin
    is_dup = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (mem[i] == data_in_sync)) begin
        is_dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dup_hit <= 1'b0;
    end else begin
      dup_hit <= wr_en_sync && is_dup;
    end
  end
`else
  assign is_dup  = 1'b0;
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    rd_ok   = rd_en && !empty;
    wr_ok   = wr_en_sync && !is_dup && (!full || rd_ok);
    ovf_nxt = wr_en_sync && !is_dup && full && !rd_ok;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_sync   <= 1'b0;
      data_in_sync <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      q            <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      wr_en_sync   <= wr_en;
      data_in_sync <= data_in;
      overflow     <= ovf_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage is not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= data_in_sync;
    end
  end

endmodule
